approx_mul_share_ctrl: RTL and testbench
========================================

# approx_mul_share_ctrl

Shared-multiplier controller that time-multiplexes one unsigned 8x8 multiplier core among `NUM_REQ` requesters. Each request selects either the exact product or the l=2 approximate product, which truncates rows 0 and 1 into OR/AND compressed bits 6..8. The block sits between the requesting datapath lanes and a single multiplier instance. It provides round-robin arbitration, a fixed two-stage pipeline, backpressure, and a tagged response bus.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response tag.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_x`  in  NUM_REQ*8  operand x of requester i in bits [8i+7:8i].
- `req_y`  in  NUM_REQ*8  operand y of requester i in bits [8i+7:8i].
- `req_exact`  in  NUM_REQ  1 selects the exact product, 0 selects the approximate product.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  ID_W  index of the originating requester.
- `rsp_z`  out  16  product.
- `rsp_exact`  out  1  echo of the mode bit.
- `busy`  out  1  high when either pipeline stage holds valid data.

## Operation
- **Exact product:** `z = x*y`.
- **Approximate product:**
  - Define `p1 = y & {8{x[0]}}` and `p2 = y & {8{x[1]}}`.
  - `z = (y*x[7:2])<<2 + (p1[6]|p2[5])<<6 + (p1[7]|p2[6])<<7 + (p1[7]&p2[6])<<8 + p2[7]<<8`.
  - The sum is computed at 16 bits with no overflow possible; the maximum is 64964.
- **Arbitration:**
  - Round-robin with pointer `rr`. The search starts at `rr` and wraps modulo `NUM_REQ`.
  - The first i with `req_valid[i]=1` wins.
  - `req_ready[i]` is high only for the winner, and only when stage A can load.
  - `req_ready` may depend combinationally on `req_valid`.
- **Handshakes:**
  - A request transfers on `req_valid[i] & req_ready[i]`.
  - A response transfers on `rsp_valid & rsp_ready`.
  - Requesters must hold x, y and exact stable while valid and not ready.
- **Pointer update:** on a transfer from requester g, `rr <= (g+1) mod NUM_REQ`. With no transfer, `rr` holds.
- **Pipeline:**
  - Stage A registers x, y, exact and id.
  - Stage B registers the computed z, exact and id.
  - `rsp_*` outputs are driven directly from stage B.
  - `b_load = !b_valid | rsp_ready`.
  - `a_load = !a_valid | b_load`.
  - When `!b_load`, both stages hold and all `req_ready` bits are 0.
- **Reset values:** `rr=0`, `a_valid=0`, `b_valid=0`, `rsp_valid=0`, `rsp_z=0`, `rsp_id=0`, `rsp_exact=0`, `req_ready=0`, `busy=0`.
- **Boundary conditions:**
  - No requests valid: no grant, and `rr` holds.
  - All requests valid: grants rotate 0,1,2,3,0...
  - Stage B drains (response consumed) in the same cycle a new request is accepted: throughput is one transaction per cycle with no bubble.
  - Reset asserted mid-operation: in-flight transactions are discarded and never reported.

## Timing
- Latency: a request accepted at edge t produces `rsp_valid` high in the cycle after edge t+1, i.e. 2 cycles, when there is no stall.
- Throughput: 1 transaction per cycle.
- A stall adds exactly the number of cycles that `rsp_ready` is low while `rsp_valid` is high.
- `rsp_*` outputs are stable while `rsp_valid & !rsp_ready`.
- Critical path: stage A registers -> multiplier -> stage B registers. The arbiter path runs from `req_valid` to `req_ready`.

## Structure
- **Package `approx_mul_pkg`** contains:
  - the approximation level constant `L = 2`;
  - the data width constant 8;
  - function `approx_mul_l2(x, y)` returning 16 bits;
  - the request struct (x, y, exact, id).
- **Sub-module `approx_mul_core`:** combinational, with inputs x, y, exact and output z. It selects between `x*y` and `approx_mul_l2`. The controller instantiates it once between stage A and stage B.
- **Arbiter:** inline in the controller as a rotate–priority-encode–rotate-back circuit.

## Test plan
- **Single exact request:** requester 2 sends x=3, y=3, exact=1, with `rsp_ready=1`. Expect `rsp_z=9`, `rsp_id=2`, 2 cycles after acceptance.
- **Approximate corner cases:**
  - x=255, y=255, exact=0 -> `rsp_z=64964`; the exact=1 version -> `65025`.
  - x=3, y=3, exact=0 -> `0`.
- **Round-robin fairness:** all 4 requesters valid continuously. Expect grants in order 0,1,2,3,0,1, one per cycle, and `rsp_id` following the same sequence.
- **Backpressure:**
  - Hold `rsp_ready=0` for 5 cycles while responses are pending.
  - Expect `rsp_z` and `rsp_id` held stable, `req_ready` all 0, and no response lost or duplicated after release.
  - Expect throughput to resume at 1 per cycle after release.
- **Reset mid-flight:**
  - Assert `rst_n=0` with both stages valid.
  - Expect `rsp_valid=0` immediately (asynchronously) and `busy=0`.
  - After release, the first grant goes to requester 0.
- **Random scoreboard:** 10k random x, y and mode values with random valid/ready toggling. Every response must match the package reference function and carry the correct id, in order per requester.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate-multiplier controller slice:
// widths, the l=2 approximate product reference and the request record.
package approx_mul_pkg;

  localparam int L        = 2;
  localparam int DATA_W   = 8;
  localparam int ID_MAX_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0]   x;
    logic [DATA_W-1:0]   y;
    logic                exact;
    logic [ID_MAX_W-1:0] id;
  } mul_req_t;

  // Rows 0 and 1 are dropped from the array; their upper bits are folded
  // back in as OR/AND compressed terms at weights 6..8.
  function automatic logic [15:0] approx_mul_l2(input logic [7:0] x,
                                                 input logic [7:0] y);
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [15:0] hi;
    logic [15:0] lo;
    p1 = y & {8{x[0]}};
    p2 = y & {8{x[1]}};
    hi = ({8'd0, y} * {10'd0, x[7:2]}) << L;
    lo = (16'(p1[6] | p2[5]) << 6) + (16'(p1[7] | p2[6]) << 7) +
         (16'(p1[7] & p2[6]) << 8) + (16'(p2[7]) << 8);
    return hi + lo;
  endfunction

endpackage

// File: rtl/approx_mul_share_ctrl_if.sv
// Request/response bus between the requesting lanes and the shared
// multiplier controller. The master side is the requester/consumer.
interface approx_mul_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_x;
  logic [NUM_REQ*8-1:0] req_y;
  logic [NUM_REQ-1:0]   req_exact;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_z;
  logic                 rsp_exact;

  modport master (
    output req_valid, req_x, req_y, req_exact, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_exact
  );

  modport slave (
    input  req_valid, req_x, req_y, req_exact, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_exact
  );

endinterface

// File: rtl/approx_mul_core.sv
// Combinational 8x8 multiplier returning either the exact product or the
// l=2 approximate product.
module approx_mul_core
  import approx_mul_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              exact,
  output logic [15:0]       z
);

  // Mode select between the full product and the truncated-row product.
  always_comb begin
    z = exact ? ({8'd0, x} * {8'd0, y}) : approx_mul_l2(x, y);
  end

endmodule

// File: rtl/approx_mul_share_ctrl.sv
// Round-robin controller that shares one multiplier core between NUM_REQ
// lanes through a two-stage (operand / product) pipeline with backpressure.
module approx_mul_share_ctrl
  import approx_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  approx_mul_share_ctrl_if.slave  bus,
  output logic                    busy
);

  logic [ID_W-1:0]    rr;
  logic [ID_W-1:0]    gnt;
  logic [ID_W-1:0]    offset;
  logic [NUM_REQ-1:0] rot_valid;
  logic               found;
  logic               b_load;
  logic               a_load;
  logic               take;
  mul_req_t           sel_req;
  mul_req_t           a_req;
  logic               a_valid;
  logic               b_valid;
  logic [15:0]        b_z;
  logic               b_exact;
  logic [ID_W-1:0]    b_id;
  logic [15:0]        core_z;

  assign b_load = !b_valid | bus.rsp_ready;
  assign a_load = !a_valid | b_load;
  // A stalled stage B freezes stage A too, even when A is empty.
  assign take   = found & a_load & b_load & rst_n;

  // Rotate valids so rr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    rot_valid = '0;
    found     = 1'b0;
    offset    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot_valid[i] = bus.req_valid[ID_W'((i + int'(rr)) % NUM_REQ)];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        found  = 1'b1;
        offset = ID_W'(i);
      end
    end
    gnt = ID_W'((int'(rr) + int'(offset)) % NUM_REQ);
  end

  // One-hot accept for the winner and operand mux for stage A.
  always_comb begin
    bus.req_ready = '0;
    if (take) begin
      bus.req_ready[gnt] = 1'b1;
    end
    sel_req.x     = bus.req_x[gnt*8 +: 8];
    sel_req.y     = bus.req_y[gnt*8 +: 8];
    sel_req.exact = bus.req_exact[gnt];
    sel_req.id    = ID_MAX_W'(gnt);
  end

  // Round-robin pointer moves past the lane that just transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (take) begin
      rr <= ID_W'((int'(gnt) + 1) % NUM_REQ);
    end
  end

  // Stage A: registered operands of the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_req   <= '0;
    end else if (b_load) begin
      a_valid <= found;
      if (found) begin
        a_req <= sel_req;
      end
    end
  end

  approx_mul_core u_core (
    .x     (a_req.x),
    .y     (a_req.y),
    .exact (a_req.exact),
    .z     (core_z)
  );

  // Stage B: registered product, which directly drives the response bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_z     <= '0;
      b_exact <= 1'b0;
      b_id    <= '0;
    end else if (b_load) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_z     <= core_z;
        b_exact <= a_req.exact;
        b_id    <= a_req.id[ID_W-1:0];
      end
    end
  end

  assign bus.rsp_valid = b_valid;
  assign bus.rsp_z     = b_z;
  assign bus.rsp_exact = b_exact;
  assign bus.rsp_id    = b_id;
  assign busy          = a_valid | b_valid;

endmodule

// File: tb/tb_approx_mul_share_ctrl.sv
// Directed and scoreboarded bench for the shared approximate-multiplier
// controller with four requesters.
module tb_approx_mul_share_ctrl;
  import approx_mul_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int N_RAND  = 10000;

  typedef struct {
    int          id;
    logic [15:0] z;
    logic        ex;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  approx_mul_share_ctrl_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  approx_mul_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int lane, input logic [7:0] x,
                               input logic [7:0] y, input logic ex,
                               input logic v);
    bus.req_x[lane*8 +: 8] = x;
    bus.req_y[lane*8 +: 8] = y;
    bus.req_exact[lane]    = ex;
    bus.req_valid[lane]    = v;
  endtask

  task automatic runOne(input int lane, input logic [7:0] x, input logic [7:0] y,
                        input logic ex, input logic [15:0] expz, input string tag);
    int n;
    @(negedge clk);
    applyStimulus(lane, x, y, ex, 1'b1);
    #1;
    n = 0;
    while (!bus.req_ready[lane] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_grant"}, 32'(n < 20), 1);
    @(negedge clk);
    applyStimulus(lane, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_z"}, bus.rsp_z, expz);
    checkOutput({tag, "_id"}, bus.rsp_id, lane);
    checkOutput({tag, "_exact"}, bus.rsp_exact, ex);
  endtask

  logic [7:0] rx [NUM_REQ];
  logic [7:0] ry [NUM_REQ];
  logic       re [NUM_REQ];
  bit         pend [NUM_REQ];
  bit         sent [NUM_REQ];
  exp_t       sbq [$];

  initial begin
    int   issued;
    int   npend;
    int   cyc;
    int   multi;
    exp_t e;

    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_exact = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_rsp_z", bus.rsp_z, 0);
    checkOutput("rst_rsp_id", bus.rsp_id, 0);
    checkOutput("rst_rsp_exact", bus.rsp_exact, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single exact request from lane 2, two-cycle latency
    @(negedge clk);
    applyStimulus(2, 8'd3, 8'd3, 1'b1, 1'b1);
    #1;
    checkOutput("single_ready", bus.req_ready, 4'b0100);
    @(negedge clk);
    applyStimulus(2, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    checkOutput("single_lat1_valid", bus.rsp_valid, 0);
    checkOutput("single_lat1_busy", busy, 1);
    @(negedge clk);
    #1;
    checkOutput("single_valid", bus.rsp_valid, 1);
    checkOutput("single_z", bus.rsp_z, 9);
    checkOutput("single_id", bus.rsp_id, 2);
    checkOutput("single_exact", bus.rsp_exact, 1);
    @(negedge clk);
    #1;
    checkOutput("single_drained", bus.rsp_valid, 0);
    checkOutput("single_idle", busy, 0);

    // approximate/exact corner products
    runOne(0, 8'd255, 8'd255, 1'b0, 16'd64964, "apx_max");
    runOne(1, 8'd255, 8'd255, 1'b1, 16'd65025, "exact_max");
    runOne(3, 8'd3,   8'd3,   1'b0, 16'd0,     "apx_small");
    runOne(2, 8'd6,   8'd5,   1'b0, 16'd20,    "apx_6x5");
    runOne(1, 8'd6,   8'd5,   1'b1, 16'd30,    "exact_6x5");
    runOne(2, 8'h43,  8'hC0,  1'b0, 16'd12992, "apx_mix");
    runOne(0, 8'h43,  8'hC0,  1'b1, 16'd12864, "exact_mix");

    // reset with both stages full
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 8'(i + 1), 8'd10, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_pre_busy", busy, 1);
    checkOutput("mid_pre_valid", bus.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rsp_valid", bus.rsp_valid, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_req_ready", bus.req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // all lanes valid: grants rotate from lane 0, responses follow two later
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput($sformatf("rr_grant%0d", k), bus.req_ready, 4'b0001 << (k % 4));
      if (k < 2) begin
        checkOutput($sformatf("rr_novalid%0d", k), bus.rsp_valid, 0);
      end else begin
        checkOutput($sformatf("rr_valid%0d", k), bus.rsp_valid, 1);
        checkOutput($sformatf("rr_id%0d", k), bus.rsp_id, (k - 2) % 4);
        checkOutput($sformatf("rr_z%0d", k), bus.rsp_z, ((k - 2) % 4 + 1) * 10);
      end
    end

    // five cycles of backpressure, then resume at full rate
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput($sformatf("bp_ready%0d", s), bus.req_ready, 0);
      checkOutput($sformatf("bp_valid%0d", s), bus.rsp_valid, 1);
      checkOutput($sformatf("bp_id%0d", s), bus.rsp_id, 2);
      checkOutput($sformatf("bp_z%0d", s), bus.rsp_z, 30);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput($sformatf("rel_valid%0d", j), bus.rsp_valid, 1);
      checkOutput($sformatf("rel_id%0d", j), bus.rsp_id, (2 + j) % 4);
      checkOutput($sformatf("rel_z%0d", j), bus.rsp_z, ((2 + j) % 4 + 1) * 10);
      checkOutput($sformatf("rel_grant%0d", j), bus.req_ready, 4'b0001 << (j % 4));
    end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);

    // random traffic against a scoreboard
    issued = 0;
    npend  = 0;
    cyc    = 0;
    multi  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0;
      sent[i] = 1'b0;
    end
    while ((issued < N_RAND || npend > 0 || sbq.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sent[i]) begin
          applyStimulus(i, 8'd0, 8'd0, 1'b0, 1'b0);
          sent[i] = 1'b0;
        end
        if (!pend[i] && issued < N_RAND && $urandom_range(0, 1) == 1) begin
          rx[i]   = 8'($urandom_range(0, 255));
          ry[i]   = 8'($urandom_range(0, 255));
          re[i]   = 1'($urandom_range(0, 1));
          pend[i] = 1'b1;
          issued++;
          npend++;
          applyStimulus(i, rx[i], ry[i], re[i], 1'b1);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!$onehot0(bus.req_ready)) multi++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pend[i] && bus.req_ready[i]) begin
          e.id = i;
          e.ex = re[i];
          e.z  = re[i] ? ({8'd0, rx[i]} * {8'd0, ry[i]}) : approx_mul_l2(rx[i], ry[i]);
          sbq.push_back(e);
          pend[i] = 1'b0;
          sent[i] = 1'b1;
          npend--;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_spurious", 1, 0);
        end else begin
          e = sbq.pop_front();
          checkOutput("sb_z", bus.rsp_z, e.z);
          checkOutput("sb_id", bus.rsp_id, e.id);
          checkOutput("sb_exact", bus.rsp_exact, e.ex);
        end
      end
      cyc++;
    end
    @(negedge clk);
    bus.req_valid = '0;
    checkOutput("sb_in_time", 32'(cyc < 60000), 1);
    checkOutput("sb_issued", issued, N_RAND);
    checkOutput("sb_left", sbq.size(), 0);
    checkOutput("sb_onehot", multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
